// File: rtl/vga_pattern_gen.sv
// VGA timing and four-pattern test generator clocked from CLOCK_50 with a pixel-rate divider.
// Optional macro VGA_BORDER_EN forces a one-pixel all-ones frame around the active area.
module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int COLOR_W  = 4,
    parameter bit SYNC_POL = 1'b0,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic               CLOCK_50,
    input  logic               i_rst,
    input  logic [1:0]         i_sel,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_de,
    output logic [XW-1:0]      o_x,
    output logic [YW-1:0]      o_y,
    output logic               o_frame_start,
    output logic [COLOR_W-1:0] o_red,
    output logic [COLOR_W-1:0] o_grn,
    output logic [COLOR_W-1:0] o_blu
);

    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_BEG   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_BEG   = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam int            BAR_W    = H_ACTIVE / 8;
    localparam int            BW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
`ifdef VGA_BORDER_EN
    localparam logic [XW-1:0] X_RIGHT  = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_BOTTOM = YW'(V_ACTIVE - 1);
`endif

    logic          tick;
    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    logic [1:0]    sel_q;
    logic [2:0]    bar_idx;
    logic [BW-1:0] bar_pix;

    generate
        if (CLK_DIV > 1) begin : g_div
            localparam int            DW       = $clog2(CLK_DIV);
            localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
            logic [DW-1:0] div_cnt;

            always_ff @(posedge CLOCK_50 or posedge i_rst) begin
                if (i_rst)
                    div_cnt <= '0;
                else if (div_cnt == DIV_LAST)
                    div_cnt <= '0;
                else
                    div_cnt <= div_cnt + 1'b1;
            end

            assign tick = (div_cnt == DIV_LAST);
        end else begin : g_nodiv
            assign tick = 1'b1;
        end
    endgenerate

    logic               first_px;
    logic               h_last;
    logic               v_last;
    logic               active;
    logic               check_on;
    logic [1:0]         sel_eff;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] grn;
    logic [COLOR_W-1:0] blu;

    always_comb begin
        first_px = (h_cnt == '0) && (v_cnt == '0);
        h_last   = (h_cnt == H_LAST);
        v_last   = (v_cnt == V_LAST);
        active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        check_on = 1'((h_cnt >> 5)) ^ 1'((v_cnt >> 5));
        // The select sampled at (0,0) must already govern pixel (0,0) itself.
        sel_eff  = first_px ? i_sel : sel_q;
        red      = '0;
        grn      = '0;
        blu      = '0;
        case (sel_eff)
            2'd0: begin
                red = {COLOR_W{bar_idx[2]}};
                grn = {COLOR_W{bar_idx[1]}};
                blu = {COLOR_W{bar_idx[0]}};
            end
            2'd1: begin
                red = {COLOR_W{check_on}};
                grn = {COLOR_W{check_on}};
                blu = {COLOR_W{check_on}};
            end
            2'd2: begin
                red = COLOR_W'(h_cnt >> 4);
                grn = COLOR_W'(v_cnt >> 4);
            end
            default: blu = '1;
        endcase
`ifdef VGA_BORDER_EN
        if (h_cnt == '0 || h_cnt == X_RIGHT || v_cnt == '0 || v_cnt == Y_BOTTOM) begin
            red = '1;
            grn = '1;
            blu = '1;
        end
`endif
        if (!active) begin
            red = '0;
            grn = '0;
            blu = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge i_rst) begin
        if (i_rst) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            sel_q         <= '0;
            bar_idx       <= '0;
            bar_pix       <= '0;
            o_hsync       <= ~SYNC_POL;
            o_vsync       <= ~SYNC_POL;
            o_de          <= 1'b0;
            o_frame_start <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_red         <= '0;
            o_grn         <= '0;
            o_blu         <= '0;
        end else begin
            o_frame_start <= 1'b0;
            if (tick) begin
                h_cnt <= h_last ? '0 : h_cnt + 1'b1;
                if (h_last)
                    v_cnt <= v_last ? '0 : v_cnt + 1'b1;
                if (first_px)
                    sel_q <= i_sel;
                // bar_idx/bar_pix always describe the pixel currently held in h_cnt.
                if (h_last) begin
                    bar_idx <= '0;
                    bar_pix <= '0;
                end else if (bar_pix == BAR_LAST) begin
                    bar_idx <= bar_idx + 1'b1;
                    bar_pix <= '0;
                end else begin
                    bar_pix <= bar_pix + 1'b1;
                end
                o_hsync       <= (h_cnt >= HS_BEG && h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
                o_vsync       <= (v_cnt >= VS_BEG && v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
                o_de          <= active;
                o_frame_start <= first_px;
                o_x           <= h_cnt;
                o_y           <= v_cnt;
                o_red         <= red;
                o_grn         <= grn;
                o_blu         <= blu;
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen on a shrunken 80x56 raster (64x48 active, CLK_DIV=2).
// Expected pixels are queued up front; a negedge monitor pops them as the DUT presents them.
module tb_vga_pattern_gen;

    localparam int H_ACTIVE = 64;
    localparam int V_ACTIVE = 48;
    localparam int XW       = 7;
    localparam int YW       = 6;
    localparam int LIMIT    = 20000;

    typedef struct {
        int x;
        int y;
        bit hs;
        bit vs;
        bit de;
        int r;
        int g;
        int b;
    } pix_t;

    logic          clk = 1'b0;
    logic          i_rst;
    logic [1:0]    i_sel;
    logic          o_hsync;
    logic          o_vsync;
    logic          o_de;
    logic [XW-1:0] o_x;
    logic [YW-1:0] o_y;
    logic          o_frame_start;
    logic [3:0]    o_red;
    logic [3:0]    o_grn;
    logic [3:0]    o_blu;

    int     errors = 0;
    int     checks = 0;
    longint cyc    = 0;
    pix_t   sb[$];

    vga_pattern_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .CLK_DIV(2), .COLOR_W(4), .SYNC_POL(1'b0)
    ) dut (
        .CLOCK_50     (clk),
        .i_rst        (i_rst),
        .i_sel        (i_sel),
        .o_hsync      (o_hsync),
        .o_vsync      (o_vsync),
        .o_de         (o_de),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_frame_start(o_frame_start),
        .o_red        (o_red),
        .o_grn        (o_grn),
        .o_blu        (o_blu)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void push(input int x, input int y, input bit hs, input bit vs,
                                 input bit de, input int r, input int g, input int b);
        pix_t p;
`ifdef VGA_BORDER_EN
        if (de && (x == 0 || x == H_ACTIVE - 1 || y == 0 || y == V_ACTIVE - 1)) begin
            r = 15;
            g = 15;
            b = 15;
        end
`endif
        p.x = x; p.y = y; p.hs = hs; p.vs = vs; p.de = de; p.r = r; p.g = g; p.b = b;
        sb.push_back(p);
    endfunction

    function automatic bit sig(input int which);
        case (which)
            0:       return o_hsync;
            1:       return o_vsync;
            default: return o_de;
        endcase
    endfunction

    task automatic wait_level(input int which, input bit level, input string tag, output longint t);
        int n = 0;
        while (sig(which) != level && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for level %0d", tag, level);
        end
        t = cyc;
    endtask

    task automatic wait_xy(input int x, input int y, input bit use_x, input string tag);
        int n = 0;
        while (!((int'(o_y) == y) && (!use_x || int'(o_x) == x)) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout at x=%0d y=%0d, required x=%0d y=%0d", tag, o_x, o_y, x, y);
        end
    endtask

    task automatic wait_fs(input string tag);
        int n = 0;
        while (!o_frame_start && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, frame_start=%0d required 1", tag, o_frame_start);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hsync"}, o_hsync, 1);
        chk({tag, "_vsync"}, o_vsync, 1);
        chk({tag, "_de"}, o_de, 0);
        chk({tag, "_fs"}, o_frame_start, 0);
        chk({tag, "_x"}, o_x, 0);
        chk({tag, "_y"}, o_y, 0);
        chk({tag, "_rgb"}, {o_red, o_grn, o_blu}, 0);
    endtask

    task automatic release_and_check(input string tag);
        @(negedge clk);
        i_rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("%s_fs_cycle%0d", tag, k), o_frame_start, (k == 2) ? 1 : 0);
        end
    endtask

    task automatic timing_seq();
        longint t0, t1, t2, t3, t4, t5, t6;
        wait_level(0, 1'b0, "hs_fall", t0);
        chk("hs_fall_x", o_x, 68);
        wait_level(0, 1'b1, "hs_rise", t1);
        chk("hs_low_cycles", t1 - t0, 16);
        wait_level(0, 1'b0, "hs_fall2", t2);
        chk("hs_period_cycles", t2 - t0, 160);
        wait_level(2, 1'b1, "de_rise", t3);
        wait_level(2, 1'b0, "de_fall", t4);
        chk("de_high_cycles", t4 - t3, 128);
        wait_level(1, 1'b0, "vs_fall", t5);
        chk("vs_fall_y", o_y, 50);
        wait_level(1, 1'b1, "vs_rise", t6);
        chk("vs_low_cycles", t6 - t5, 320);
    endtask

    task automatic stim_seq();
        wait_xy(0, 20, 1'b0, "f0_line20");
        i_sel = 2'd3;                       // mid-frame: bars must persist
        wait_fs("f1_start");
        wait_xy(0, 30, 1'b0, "f1_line30");
        i_sel = 2'd1;
        wait_fs("f2_start");
        wait_xy(0, 30, 1'b0, "f2_line30");
        i_sel = 2'd2;
        wait_fs("f3_start");
        wait_xy(30, 20, 1'b1, "f3_x30_y20");
        i_rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (5) @(negedge clk);
        i_sel = 2'd3;
        release_and_check("midrel");
        wait_xy(0, 6, 1'b0, "post_line6");
        repeat (4) @(negedge clk);
    endtask

    // Monitor: a pixel is presented when the coordinates change or frame_start marks (0,0).
    initial begin : monitor
        logic [XW-1:0] prev_x = '1;
        logic [YW-1:0] prev_y = '1;
        pix_t          e;
        forever begin
            @(negedge clk);
            if (!i_rst && (o_frame_start || o_x != prev_x || o_y != prev_y)) begin
                if (sb.size() > 0 && int'(o_x) == sb[0].x && int'(o_y) == sb[0].y) begin
                    e = sb.pop_front();
                    $display("pix (%0d,%0d) hs=%0d vs=%0d de=%0d rgb=%h/%h/%h",
                             o_x, o_y, o_hsync, o_vsync, o_de, o_red, o_grn, o_blu);
                    chk($sformatf("pix_%0d_%0d", e.x, e.y),
                        {o_hsync, o_vsync, o_de, o_red, o_grn, o_blu},
                        {e.hs, e.vs, e.de, 4'(e.r), 4'(e.g), 4'(e.b)});
                end
            end
            prev_x = o_x;
            prev_y = o_y;
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        pix_t p;
        i_rst = 1'b1;
        i_sel = 2'd0;

        // frame 0: bars (8-pixel bars), plus blanking/sync samples
        push( 0,  0, 1, 1, 1,  0,  0,  0);
        push( 8,  1, 1, 1, 1,  0,  0, 15);
        push(20,  1, 1, 1, 1,  0, 15,  0);
        push(63,  3, 1, 1, 1, 15, 15, 15);
        push(64,  3, 1, 1, 0,  0,  0,  0);
        push(70,  3, 0, 1, 0,  0,  0,  0);
        push(79,  3, 1, 1, 0,  0,  0,  0);
        push(40, 10, 1, 1, 1, 15,  0, 15);
        push(40, 30, 1, 1, 1, 15,  0, 15);
        push(56, 30, 1, 1, 1, 15, 15, 15);
        push(10, 50, 1, 0, 0,  0,  0,  0);
        push(10, 52, 1, 1, 0,  0,  0,  0);
        // frame 1: solid blue
        push( 0,  0, 1, 1, 1,  0,  0, 15);
        push( 0,  5, 1, 1, 1,  0,  0, 15);
        push(30, 20, 1, 1, 1,  0,  0, 15);
        // frame 2: checker
        push( 0,  0, 1, 1, 1,  0,  0,  0);
        push(32,  1, 1, 1, 1, 15, 15, 15);
        push(33, 33, 1, 1, 1,  0,  0,  0);
        push(10, 40, 1, 1, 1, 15, 15, 15);
        push(40, 40, 1, 1, 1,  0,  0,  0);
        // frame 3: gradient
        push( 0,  0, 1, 1, 1,  0,  0,  0);
        push(17,  1, 1, 1, 1,  1,  0,  0);
        push(16, 16, 1, 1, 1,  1,  1,  0);
        push(50, 16, 1, 1, 1,  3,  1,  0);
        // after mid-frame reset: solid blue restarting at (0,0)
        push( 0,  0, 1, 1, 1,  0,  0, 15);
        push( 0,  5, 1, 1, 1,  0,  0, 15);

        repeat (5) @(negedge clk);
        check_reset_outputs("rst");
        release_and_check("rel");

        fork
            timing_seq();
            stim_seq();
        join

        while (sb.size() > 0) begin
            p = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL pix_%0d_%0d: never presented, entry still queued", p.x, p.y);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
